// File: rtl/conv_enc_213_src.sv
// conv_enc_213_src
// Framed (2,1,3) convolutional encoder (g1=1011, g2=1111) and symbol pacer feeding a
// Viterbi decoder. Each frame carries FRAME_LEN information bits followed by 3 zero
// tail bits. Every symbol is held for FIRST_GAP clocks while the decoder trellis
// fills (first FILL_SYMS symbols) and for TB_GAP clocks once tracebacks begin.
//
// Ports:
//   clock      - sole clock, rising edge
//   reset      - synchronous, active-high
//   start      - frame start pulse, honoured only when idle
//   data_in    - information bit
//   data_valid - data_in valid
//   data_ready - block accepts data_in this cycle
//   err_mask   - XORed onto the issued symbol (channel error injection)
//   Rx         - registered encoded symbol {v1,v2}
//   seq_ready  - high while the frame's symbols are presented
//   underrun   - sticky, an info slot found data_valid low
//   frame_done - one-cycle pulse at end of frame
module conv_enc_213_src #(
  parameter int unsigned FRAME_LEN = 20,
  parameter int unsigned FILL_SYMS = 15,
  parameter int unsigned FIRST_GAP = 3,
  parameter int unsigned TB_GAP    = 19
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic [1:0] err_mask,
  output logic [1:0] Rx,
  output logic       seq_ready,
  output logic       underrun,
  output logic       frame_done
);

  typedef enum logic [1:0] {StIdle, StSend, StTail, StEnd} state_e;

  localparam logic [15:0] LastInfo  = 16'(FRAME_LEN - 1);
  localparam logic [15:0] LastSym   = 16'(FRAME_LEN + 2);
  localparam logic [15:0] FillSyms  = 16'(FILL_SYMS);
  localparam logic [15:0] FirstHold = 16'(FIRST_GAP - 1);
  localparam logic [15:0] TbHold    = 16'(TB_GAP - 1);

  state_e      state_q, state_d;
  logic [2:0]  s_q, s_d;
  logic [15:0] sym_cnt_q, sym_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]  rx_q, rx_d;
  logic        seq_ready_q, seq_ready_d;
  logic        underrun_q, underrun_d;
  logic        frame_done_q, frame_done_d;

  logic slot_free;
  logic issue;
  logic u;
  logic v1, v2;

  assign slot_free = (hold_cnt_q == 16'd0);
  // Tail symbols always encode a zero input bit.
  assign u         = (state_q == StSend) ? data_in : 1'b0;
  assign v1        = u ^ s_q[1] ^ s_q[2];
  assign v2        = u ^ s_q[0] ^ s_q[1] ^ s_q[2];
  assign issue     = slot_free &&
                     (((state_q == StSend) && data_valid) || (state_q == StTail));

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    sym_cnt_d    = sym_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    rx_d         = rx_q;
    seq_ready_d  = seq_ready_q;
    underrun_d   = underrun_q;
    frame_done_d = 1'b0;

    if (issue) begin
      // The error mask touches only the channel symbol, never the encoder state.
      rx_d        = {v1, v2} ^ err_mask;
      hold_cnt_d  = (sym_cnt_q < FillSyms) ? FirstHold : TbHold;
      sym_cnt_d   = (sym_cnt_q == LastSym) ? sym_cnt_q : sym_cnt_q + 16'd1;
      s_d         = {s_q[1:0], u};
      seq_ready_d = 1'b1;
    end else if (hold_cnt_q != 16'd0) begin
      hold_cnt_d = hold_cnt_q - 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        // A start coinciding with the frame_done pulse is dropped.
        if (start && !frame_done_q) begin
          state_d    = StSend;
          s_d        = 3'b000;
          sym_cnt_d  = 16'd0;
          hold_cnt_d = 16'd0;
          underrun_d = 1'b0;
        end
      end
      StSend: begin
        if (slot_free && !data_valid) begin
          underrun_d = 1'b1;
        end else if (issue && (sym_cnt_q == LastInfo)) begin
          state_d = StTail;
        end
      end
      StTail: begin
        if (issue && (sym_cnt_q == LastSym)) begin
          state_d = StEnd;
        end
      end
      StEnd: begin
        if (slot_free) begin
          state_d      = StIdle;
          seq_ready_d  = 1'b0;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      s_q          <= 3'b000;
      sym_cnt_q    <= 16'd0;
      hold_cnt_q   <= 16'd0;
      rx_q         <= 2'b00;
      seq_ready_q  <= 1'b0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      sym_cnt_q    <= sym_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      rx_q         <= rx_d;
      seq_ready_q  <= seq_ready_d;
      underrun_q   <= underrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign data_ready = (state_q == StSend) && slot_free;
  assign Rx         = rx_q;
  assign seq_ready  = seq_ready_q;
  assign underrun   = underrun_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_enc_213_src.sv
// Directed bench for conv_enc_213_src with default parameters.
module tb_conv_enc_213_src;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       data_in;
  logic       data_valid;
  logic       data_ready;
  logic [1:0] err_mask;
  logic [1:0] Rx;
  logic       seq_ready;
  logic       underrun;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Info bits; the first four (0,1,1,0) give the hand-derived symbols 00,11,10,10.
  logic [0:19] frame_bits = 20'b0110_1011_1001_0100_1101;
  logic [1:0]  hand_syms [4] = '{2'b00, 2'b11, 2'b10, 2'b10};

  conv_enc_213_src dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .err_mask  (err_mask),
    .Rx        (Rx),
    .seq_ready (seq_ready),
    .underrun  (underrun),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame. stall_at: symbol whose slot sees data_valid low for 5 cycles.
  // err_at/err_val: symbol given a channel error. reset_at: symbol after which reset hits.
  // start_mid: pulse start during SEND.
  task automatic run_frame(input int stall_at, input int err_at, input logic [1:0] err_val,
                           input int reset_at, input bit start_mid);
    logic [2:0] ms;
    logic       ub;
    logic [1:0] exp_sym;
    logic [1:0] last_sym;
    logic [1:0] mask;
    int         gap;
    ms       = 3'b000;
    last_sym = 2'b00;
    start    = 1'b1;
    tick;
    start    = 1'b0;
    check("start_ready", data_ready, 1);
    check("start_seq_low", seq_ready, 0);
    check("start_underrun_clr", underrun, 0);
    for (int k = 0; k < 23; k++) begin
      ub = (k < 20) ? frame_bits[k] : 1'b0;
      if (k == stall_at) begin
        data_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
          tick;
          check("stall_rx_hold", Rx, last_sym);
          check("stall_ready", data_ready, 1);
          check("stall_underrun", underrun, 1);
        end
        data_valid = 1'b1;
      end
      // During the tail data_in is driven high; the encoder must ignore it.
      data_in  = (k < 20) ? ub : 1'b1;
      mask     = (k == err_at) ? err_val : 2'b00;
      err_mask = mask;
      tick;
      err_mask = 2'b00;
      exp_sym  = {ub ^ ms[1] ^ ms[2], ub ^ ms[0] ^ ms[1] ^ ms[2]} ^ mask;
      ms       = {ms[1:0], ub};
      last_sym = exp_sym;
      check($sformatf("sym%0d", k), Rx, exp_sym);
      check("issue_seq_ready", seq_ready, 1);
      if (k < 4) check($sformatf("hand_sym%0d", k), Rx, hand_syms[k] ^ mask);
      if (k == reset_at) begin
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("rst_rx", Rx, 0);
        check("rst_seq_ready", seq_ready, 0);
        check("rst_data_ready", data_ready, 0);
        check("rst_frame_done", frame_done, 0);
        tick;
        check("post_rst_idle_ready", data_ready, 0);
        check("post_rst_idle_seq", seq_ready, 0);
        return;
      end
      gap = (k < 15) ? 3 : 19;
      check("hold_ready0", data_ready, 0);
      for (int j = 1; j < gap; j++) begin
        if (start_mid && k == 2 && j == 1) start = 1'b1;
        tick;
        start = 1'b0;
        check("hold_rx", Rx, exp_sym);
        check("hold_seq", seq_ready, 1);
        check("hold_ready", data_ready, (j == gap - 1 && k + 1 < 20) ? 1 : 0);
      end
    end
    check("end_seq_high", seq_ready, 1);
    check("end_done_low", frame_done, 0);
    tick;
    check("end_seq_low", seq_ready, 0);
    check("end_done_pulse", frame_done, 1);
    check("end_underrun", underrun, (stall_at >= 0) ? 1 : 0);
    // A start in the frame_done cycle is dropped.
    start = 1'b1;
    tick;
    start = 1'b0;
    check("done_once", frame_done, 0);
    check("done_start_ignored", data_ready, 0);
    tick;
    check("still_idle", data_ready, 0);
    check("idle_seq_low", seq_ready, 0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    data_in    = 1'b0;
    data_valid = 1'b1;
    err_mask   = 2'b00;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("reset_rx", Rx, 0);
    check("reset_seq_ready", seq_ready, 0);
    check("reset_data_ready", data_ready, 0);
    check("reset_underrun", underrun, 0);
    check("reset_frame_done", frame_done, 0);
    reset = 1'b0;
    tick;
    check("idle_no_start", data_ready, 0);

    run_frame(-1, -1, 2'b00, -1, 1'b0);
    run_frame(4, -1, 2'b00, -1, 1'b0);
    run_frame(-1, 1, 2'b01, -1, 1'b1);
    run_frame(-1, -1, 2'b00, 17, 1'b0);
    run_frame(-1, -1, 2'b00, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_enc_213_src.md
# conv_enc_213_src

Framed (2,1,3) convolutional encoder and symbol pacer that sits directly upstream of `bVITERBI_213` and drives its `Rx` and `seq_ready` inputs. It accepts information bits over a valid/ready handshake and encodes them with generators g1=1011 and g2=1111 (memory 3, 8 states). It appends 3 zero tail bits per frame and presents each 2-bit symbol for exactly the number of clocks the decoder needs. The hold is short while the trellis fills and long once tracebacks begin. An optional per-symbol error mask lets benches inject channel errors.

## Interface
- FRAME_LEN, 20: information bits per frame; total symbols = FRAME_LEN+3.
- FILL_SYMS, 15: number of leading symbols held for FIRST_GAP clocks.
- FIRST_GAP, 3: hold length in clocks for symbols 0..FILL_SYMS-1; must be ≥1.
- TB_GAP, 19: hold length in clocks for symbols FILL_SYMS onward; must be ≥1.
- clock  in  1  sole clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  frame start pulse; honoured only in IDLE.
- data_in  in  1  information bit.
- data_valid  in  1  data_in valid.
- data_ready  out  1  block accepts data_in this cycle.
- err_mask  in  2  XORed onto the issued symbol; sampled at the issue edge.
- Rx  out  2  encoded symbol {v1,v2}; registered.
- seq_ready  out  1  high while the frame's symbols are presented.
- underrun  out  1  sticky; an info slot found data_valid low.
- frame_done  out  1  one-cycle pulse at end of frame.

## Operation
- Encoder state is s[2:0], where s[0] holds the most recent past bit. For input u: v1 = u^s[1]^s[2]; v2 = u^s[0]^s[1]^s[2]. After each issue, s <= {s[1:0],u}.
- States:
  - IDLE: on start, go to SEND. Clear s, sym_cnt, hold_cnt and underrun.
  - SEND: information bits. Leave after FRAME_LEN bits have been accepted.
  - TAIL: issues 3 symbols with u=0 automatically, with no handshake.
  - END: waits until the last tail symbol's hold expires, then pulses frame_done and returns to IDLE.
- Slot free means hold_cnt==0.
  - data_ready = (state==SEND) && slot free.
  - An issue happens when data_valid && data_ready in SEND, or when a slot is free in TAIL.
- On issue:
  - Rx <= {v1,v2}^err_mask.
  - hold_cnt <= (sym_cnt<FILL_SYMS ? FIRST_GAP : TB_GAP) - 1.
  - sym_cnt increments.
- Hold countdown: when not issuing and hold_cnt≠0, hold_cnt decrements.
- Underrun: a free slot in SEND with data_valid low sets underrun. Rx holds its last value, no state or count advances, and the slot is retried next cycle.
- err_mask affects only Rx, never s.
- start is ignored outside IDLE.
- Counters are 16-bit. sym_cnt counts 0..FRAME_LEN+2 with no wrap.

## Timing
- Reset values:
  - Rx = 2'b00.
  - seq_ready = 0, data_ready = 0.
  - underrun = 0, frame_done = 0.
  - state = IDLE, s = 0, counters = 0.
- Reset has priority over every other event, including mid-frame. On the edge after reset, all outputs hold their reset values; no partial frame continues.
- Start latency:
  - start is sampled at edge t.
  - SEND is entered at t+1, and data_ready is high during cycle t+1.
  - The first symbol can issue at edge t+2.
- seq_ready rises on the same edge that issues symbol 0. It falls on the edge where END exits; frame_done is high for exactly that one cycle.
- With no stalls, symbol k is stable for FIRST_GAP clocks (k<FILL_SYMS) or TB_GAP clocks otherwise. Issue edges are spaced exactly by the hold of the preceding symbol.
- TAIL continuity: the first tail symbol issues in the first free slot after the last info bit is accepted. There is no bubble.
- END: seq_ready drops exactly TB_GAP clocks after the last tail issue, or FIRST_GAP clocks if FRAME_LEN+2 < FILL_SYMS.
- A start arriving in the same cycle as frame_done is ignored.

## Test plan
- Encode bits 0,1,1,0 with err_mask=0 → Rx sequence 00,11,10,10. Each symbol holds 3 clocks, and data_ready is high one cycle in three.
- Full frame with defaults and continuous data_valid → 23 symbols issued. Symbols 0–14 change every 3 clocks and symbols 15–22 every 19. The last 3 symbols are the tail and return s to 000. seq_ready is high for 15·3+8·19=197 clocks, then frame_done pulses once.
- Drop data_valid for 5 cycles at symbol 4's slot → Rx holds symbol 3 for 5 extra clocks and underrun=1 until the next start. The encoded stream is otherwise identical.
- Set err_mask=2'b01 for symbol 1 (input bits 0,1,1,0) → Rx = 00,10,10,10. The subsequent symbols match the error-free run.
- Assert reset during symbol 17 → next cycle Rx=00, seq_ready=0, data_ready=0. A new start encodes from s=000.
- Pulse start during SEND → ignored, with no change to sym_cnt or s.
